rv_iommu_pc_fetch: RTL and testbench

- Process-context fetch controller. Initiator side of the PDT cache lookup/fill port.
- Takes a (device_id, process_id, pdtp) request from the translation pipeline and issues a PDTC lookup.
- On a miss, walks the in-memory PDT (PD8/PD17/PD20) through a single-outstanding memory read port, fills the PDTC, then returns the process context or a fault cause.

---
 rtl/rv_iommu_pc_fetch.sv | 235 +++++++++++++++++++++++
 tb/tb_rv_iommu_pc_fetch.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv_iommu_pc_fetch.sv
// Process-context fetch: looks up the PDT cache and, on a miss, walks PD8/PD17/PD20 tables, fills the cache, and responds.
// A process context is 128 bits: {fsc[63:0], ta[63:0]}.
module rv_iommu_pc_fetch #(
    parameter int PPN_W = 44,
    parameter int PA_W  = 56
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [23:0]       device_id_i,
    input  logic [19:0]       process_id_i,
    input  logic [3:0]        pdtp_mode_i,
    input  logic [PPN_W-1:0]  pdtp_ppn_i,
    output logic              resp_valid_o,
    input  logic              resp_ready_i,
    output logic              resp_fault_o,
    output logic [11:0]       resp_cause_o,
    output logic [127:0]      resp_pc_o,
    output logic              pdtc_lookup_o,
    output logic              pdtc_fill_o,
    output logic [23:0]       pdtc_device_id_o,
    output logic [19:0]       pdtc_process_id_o,
    output logic [127:0]      pdtc_pc_o,
    input  logic              pdtc_lkup_fill_done_i,
    input  logic              pdtc_hit_i,
    input  logic [127:0]      pdtc_pc_i,
    output logic              mem_rd_req_o,
    output logic [PA_W-1:0]   mem_rd_addr_o,
    output logic              mem_rd_size_o,
    input  logic              mem_rd_done_i,
    input  logic              mem_rd_err_i,
    input  logic [127:0]      mem_rd_data_i
);

    // state     | meaning
    // IDLE      | ready for a new request
    // LKUP      | PDTC lookup raised, waiting for done
    // LKUP_REL  | lookup dropped, waiting for done to fall
    // WALK      | memory read outstanding for the current level
    // WALK_WAIT | checking the returned PDT entry
    // FILL      | PDTC fill raised, waiting for done
    // FILL_REL  | fill dropped, waiting for done to fall
    // RESP      | response held until accepted
    typedef enum logic [2:0] {
        S_IDLE, S_LKUP, S_LKUP_REL, S_WALK, S_WALK_WAIT, S_FILL, S_FILL_REL, S_RESP
    } state_t;

    localparam logic [11:0] CAUSE_PID_WIDE = 12'd260;
    localparam logic [11:0] CAUSE_ACC_FLT  = 12'd265;
    localparam logic [11:0] CAUSE_INVALID  = 12'd266;
    localparam logic [11:0] CAUSE_MISCFG   = 12'd267;

    localparam int EXT_W = PPN_W + 12 + PA_W;

    state_t             state;
    logic [3:0]         mode_q;
    logic [PPN_W-1:0]   ppn_q;
    logic [PPN_W-1:0]   base_q;
    logic [1:0]         level_q;
    logic               hit_q;
    logic [127:0]       lk_pc_q;
    logic [127:0]       rd_data_q;
    logic               rd_err_q;

    logic [EXT_W-1:0]   root_ext;
    logic [PA_W-1:0]    root_pa;
    logic [PA_W-1:0]    idx_off;
    logic [PA_W-1:0]    walk_addr;
    logic               mode_ok;
    logic               pid_too_wide;
    logic               nl_rsvd;
    logic               leaf_rsvd;

    // Root is zero-extended then truncated so the sum wraps modulo 2^PA_W.
    always_comb begin
        root_ext = {{PA_W{1'b0}}, base_q, 12'b0};
        root_pa  = root_ext[PA_W-1:0];
        case (level_q)
            2'd2:    idx_off = PA_W'({pdtc_process_id_o[19:17], 3'b000});
            2'd1:    idx_off = PA_W'({pdtc_process_id_o[16:8], 3'b000});
            default: idx_off = PA_W'({pdtc_process_id_o[7:0], 4'b0000});
        endcase
        walk_addr = root_pa + idx_off;
    end

    always_comb begin
        mode_ok      = (pdtp_mode_i == 4'd1) || (pdtp_mode_i == 4'd2) || (pdtp_mode_i == 4'd3);
        pid_too_wide = ((pdtp_mode_i == 4'd1) && (process_id_i[19:8] != '0)) ||
                       ((pdtp_mode_i == 4'd2) && (process_id_i[19:17] != '0));
        nl_rsvd      = (rd_data_q[9:1] != '0) || (rd_data_q[63:54] != '0);
        leaf_rsvd    = (rd_data_q[11:3] != '0) || (rd_data_q[63:32] != '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state             <= S_IDLE;
            req_ready_o       <= 1'b1;
            resp_valid_o      <= 1'b0;
            resp_fault_o      <= 1'b0;
            resp_cause_o      <= '0;
            resp_pc_o         <= '0;
            pdtc_lookup_o     <= 1'b0;
            pdtc_fill_o       <= 1'b0;
            pdtc_device_id_o  <= '0;
            pdtc_process_id_o <= '0;
            pdtc_pc_o         <= '0;
            mem_rd_req_o      <= 1'b0;
            mem_rd_addr_o     <= '0;
            mem_rd_size_o     <= 1'b0;
            mode_q            <= '0;
            ppn_q             <= '0;
            base_q            <= '0;
            level_q           <= '0;
            hit_q             <= 1'b0;
            lk_pc_q           <= '0;
            rd_data_q         <= '0;
            rd_err_q          <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid_i && req_ready_o) begin
                        pdtc_device_id_o  <= device_id_i;
                        pdtc_process_id_o <= process_id_i;
                        mode_q            <= pdtp_mode_i;
                        ppn_q             <= pdtp_ppn_i;
                        pdtc_pc_o         <= '0;
                        req_ready_o       <= 1'b0;
                        if (!mode_ok) begin
                            resp_valid_o <= 1'b1;
                            resp_fault_o <= 1'b1;
                            resp_cause_o <= CAUSE_MISCFG;
                            resp_pc_o    <= '0;
                            state        <= S_RESP;
                        end else if (pid_too_wide) begin
                            resp_valid_o <= 1'b1;
                            resp_fault_o <= 1'b1;
                            resp_cause_o <= CAUSE_PID_WIDE;
                            resp_pc_o    <= '0;
                            state        <= S_RESP;
                        end else begin
                            state <= S_LKUP;
                        end
                    end
                end
                // Lookup is only raised once any stale done from the cache has fallen.
                S_LKUP: begin
                    if (!pdtc_lookup_o) begin
                        if (!pdtc_lkup_fill_done_i) pdtc_lookup_o <= 1'b1;
                    end else if (pdtc_lkup_fill_done_i) begin
                        pdtc_lookup_o <= 1'b0;
                        hit_q         <= pdtc_hit_i;
                        lk_pc_q       <= pdtc_pc_i;
                        state         <= S_LKUP_REL;
                    end
                end
                S_LKUP_REL: begin
                    if (!pdtc_lkup_fill_done_i) begin
                        if (hit_q) begin
                            resp_valid_o <= 1'b1;
                            resp_fault_o <= 1'b0;
                            resp_cause_o <= '0;
                            resp_pc_o    <= lk_pc_q;
                            state        <= S_RESP;
                        end else begin
                            base_q  <= ppn_q;
                            level_q <= (mode_q == 4'd3) ? 2'd2 : (mode_q == 4'd2) ? 2'd1 : 2'd0;
                            state   <= S_WALK;
                        end
                    end
                end
                S_WALK: begin
                    if (!mem_rd_req_o) begin
                        mem_rd_req_o  <= 1'b1;
                        mem_rd_addr_o <= walk_addr;
                        mem_rd_size_o <= (level_q == 2'd0);
                    end else if (mem_rd_done_i) begin
                        mem_rd_req_o <= 1'b0;
                        rd_data_q    <= mem_rd_data_i;
                        rd_err_q     <= mem_rd_err_i;
                        state        <= S_WALK_WAIT;
                    end
                end
                S_WALK_WAIT: begin
                    if (rd_err_q || !rd_data_q[0] ||
                        ((level_q != 2'd0) && nl_rsvd) || ((level_q == 2'd0) && leaf_rsvd)) begin
                        resp_valid_o <= 1'b1;
                        resp_fault_o <= 1'b1;
                        resp_pc_o    <= '0;
                        if (rd_err_q)           resp_cause_o <= CAUSE_ACC_FLT;
                        else if (!rd_data_q[0]) resp_cause_o <= CAUSE_INVALID;
                        else                    resp_cause_o <= CAUSE_MISCFG;
                        state        <= S_RESP;
                    end else if (level_q != 2'd0) begin
                        base_q  <= PPN_W'(rd_data_q[53:10]);
                        level_q <= level_q - 2'd1;
                        state   <= S_WALK;
                    end else begin
                        pdtc_pc_o <= rd_data_q;
                        state     <= S_FILL;
                    end
                end
                S_FILL: begin
                    if (!pdtc_fill_o) begin
                        if (!pdtc_lkup_fill_done_i) pdtc_fill_o <= 1'b1;
                    end else if (pdtc_lkup_fill_done_i) begin
                        pdtc_fill_o <= 1'b0;
                        state       <= S_FILL_REL;
                    end
                end
                S_FILL_REL: begin
                    if (!pdtc_lkup_fill_done_i) begin
                        resp_valid_o <= 1'b1;
                        resp_fault_o <= 1'b0;
                        resp_cause_o <= '0;
                        resp_pc_o    <= pdtc_pc_o;
                        state        <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (resp_ready_i) begin
                        resp_valid_o <= 1'b0;
                        resp_fault_o <= 1'b0;
                        resp_cause_o <= '0;
                        resp_pc_o    <= '0;
                        req_ready_o  <= 1'b1;
                        state        <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rv_iommu_pc_fetch.sv
// Bench for rv_iommu_pc_fetch: cycle-stepped PDTC and memory models, read-address scoreboard, per-scenario checks.
module tb_rv_iommu_pc_fetch;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid_i = 1'b0;
    logic          req_ready_o;
    logic [23:0]   device_id_i = '0;
    logic [19:0]   process_id_i = '0;
    logic [3:0]    pdtp_mode_i = '0;
    logic [43:0]   pdtp_ppn_i = '0;
    logic          resp_valid_o;
    logic          resp_ready_i = 1'b0;
    logic          resp_fault_o;
    logic [11:0]   resp_cause_o;
    logic [127:0]  resp_pc_o;
    logic          pdtc_lookup_o;
    logic          pdtc_fill_o;
    logic [23:0]   pdtc_device_id_o;
    logic [19:0]   pdtc_process_id_o;
    logic [127:0]  pdtc_pc_o;
    logic          pdtc_lkup_fill_done_i = 1'b0;
    logic          pdtc_hit_i = 1'b0;
    logic [127:0]  pdtc_pc_i = '0;
    logic          mem_rd_req_o;
    logic [55:0]   mem_rd_addr_o;
    logic          mem_rd_size_o;
    logic          mem_rd_done_i = 1'b0;
    logic          mem_rd_err_i = 1'b0;
    logic [127:0]  mem_rd_data_i = '0;

    rv_iommu_pc_fetch #(.PPN_W(44), .PA_W(56)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .device_id_i(device_id_i), .process_id_i(process_id_i),
        .pdtp_mode_i(pdtp_mode_i), .pdtp_ppn_i(pdtp_ppn_i),
        .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i),
        .resp_fault_o(resp_fault_o), .resp_cause_o(resp_cause_o), .resp_pc_o(resp_pc_o),
        .pdtc_lookup_o(pdtc_lookup_o), .pdtc_fill_o(pdtc_fill_o),
        .pdtc_device_id_o(pdtc_device_id_o), .pdtc_process_id_o(pdtc_process_id_o),
        .pdtc_pc_o(pdtc_pc_o), .pdtc_lkup_fill_done_i(pdtc_lkup_fill_done_i),
        .pdtc_hit_i(pdtc_hit_i), .pdtc_pc_i(pdtc_pc_i),
        .mem_rd_req_o(mem_rd_req_o), .mem_rd_addr_o(mem_rd_addr_o), .mem_rd_size_o(mem_rd_size_o),
        .mem_rd_done_i(mem_rd_done_i), .mem_rd_err_i(mem_rd_err_i), .mem_rd_data_i(mem_rd_data_i)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [55:0] addr;
        logic        size;
    } rd_t;

    int            checks = 0;
    int            errors = 0;

    bit            cache_hit;
    logic [127:0]  cache_pc;
    int            done_extra;
    logic [127:0]  mem_img [logic [55:0]];
    bit            err_en;
    logic [55:0]   err_addr;

    rd_t           obs_rd[$];
    rd_t           exp_rd[$];
    int            n_lkup, n_fill, viol, stall_bad;
    bit            got_resp, saw_mem, idle_ok;
    logic          r_fault;
    logic [11:0]   r_cause;
    logic [127:0]  r_pc;
    logic [127:0]  fl_pc;
    logic [23:0]   lk_dev;
    logic [19:0]   lk_pid;

    // Drives one request and plays the PDTC and memory until the response is taken.
    task automatic run_txn(input logic [23:0] dev, input logic [19:0] pid, input logic [3:0] mode,
                           input logic [43:0] ppn, input int stall, input bit abort_on_mem);
        int pd_ph = 0, pd_cnt = 0, m_ph = 0, m_cnt = 0, stall_left = 0;
        bit pd_lk = 0, prev_lk = 0, prev_fl = 0, resp_seen = 0;
        logic [55:0] m_addr = '0;
        rd_t r;
        got_resp = 0; saw_mem = 0; idle_ok = 0;
        n_lkup = 0; n_fill = 0; viol = 0; stall_bad = 0;
        obs_rd.delete();
        @(negedge clk);
        if (!req_ready_o) viol++;
        req_valid_i = 1'b1; device_id_i = dev; process_id_i = pid; pdtp_mode_i = mode; pdtp_ppn_i = ppn;
        for (int cyc = 0; cyc < 400 && !got_resp && !saw_mem; cyc++) begin
            @(negedge clk);
            req_valid_i = 1'b0;
            if (pdtc_lookup_o && pdtc_fill_o) viol++;
            if (((pdtc_lookup_o && !prev_lk) || (pdtc_fill_o && !prev_fl)) && pdtc_lkup_fill_done_i) viol++;
            prev_lk = pdtc_lookup_o; prev_fl = pdtc_fill_o;
            if (req_ready_o) viol++;
            case (pd_ph)
                0: if (pdtc_lookup_o || pdtc_fill_o) begin
                    pd_lk = pdtc_lookup_o; pd_ph = 1;
                    if (pd_lk) begin n_lkup++; lk_dev = pdtc_device_id_o; lk_pid = pdtc_process_id_o; end
                    else begin n_fill++; fl_pc = pdtc_pc_o; end
                end
                1: begin
                    pdtc_lkup_fill_done_i = 1'b1;
                    pdtc_hit_i = pd_lk ? cache_hit : 1'b1;
                    pdtc_pc_i  = pd_lk ? cache_pc : ~cache_pc;
                    pd_ph = 2;
                end
                2: if (!(pdtc_lookup_o || pdtc_fill_o)) begin
                    if (done_extra > 0) begin pd_cnt = done_extra; pd_ph = 3; end
                    else begin pdtc_lkup_fill_done_i = 1'b0; pdtc_hit_i = 1'b0; pd_ph = 0; end
                end
                default: begin
                    pd_cnt--;
                    if (pd_cnt == 0) begin pdtc_lkup_fill_done_i = 1'b0; pdtc_hit_i = 1'b0; pd_ph = 0; end
                end
            endcase
            case (m_ph)
                0: if (mem_rd_req_o) begin
                    r.addr = mem_rd_addr_o; r.size = mem_rd_size_o;
                    obs_rd.push_back(r);
                    m_addr = mem_rd_addr_o; m_cnt = 1; m_ph = 1;
                    if (abort_on_mem) saw_mem = 1;
                end
                1: begin
                    if (!mem_rd_req_o || mem_rd_addr_o !== m_addr) viol++;
                    if (m_cnt > 0) m_cnt--;
                    else begin
                        mem_rd_done_i = 1'b1;
                        mem_rd_err_i  = err_en && (m_addr == err_addr);
                        mem_rd_data_i = mem_img.exists(m_addr) ? mem_img[m_addr] : '0;
                        m_ph = 2;
                    end
                end
                default: begin
                    mem_rd_done_i = 1'b0; mem_rd_err_i = 1'b0; mem_rd_data_i = '0; m_ph = 0;
                end
            endcase
            if (resp_valid_o) begin
                if (!resp_seen) begin
                    resp_seen = 1; stall_left = stall;
                    r_fault = resp_fault_o; r_cause = resp_cause_o; r_pc = resp_pc_o;
                end else if (resp_fault_o !== r_fault || resp_cause_o !== r_cause || resp_pc_o !== r_pc) begin
                    stall_bad++;
                end
                if (stall_left == 0) begin resp_ready_i = 1'b1; got_resp = 1; end
                else stall_left--;
            end
        end
        if (got_resp) begin
            @(negedge clk);
            resp_ready_i = 1'b0;
            idle_ok = req_ready_o && !resp_valid_o;
        end
        pdtc_lkup_fill_done_i = 1'b0; pdtc_hit_i = 1'b0;
        mem_rd_done_i = 1'b0; mem_rd_err_i = 1'b0; mem_rd_data_i = '0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (req_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", req_ready_o); end
        checks++; if ({resp_valid_o, pdtc_lookup_o, pdtc_fill_o, mem_rd_req_o, resp_fault_o} !== 5'b0) begin
            errors++; $display("FAIL reset_ctl got %b exp 00000", {resp_valid_o, pdtc_lookup_o, pdtc_fill_o, mem_rd_req_o, resp_fault_o});
        end
        checks++; if ({pdtc_device_id_o, pdtc_process_id_o, mem_rd_addr_o} !== '0) begin
            errors++; $display("FAIL reset_data got %h/%h/%h exp 0", pdtc_device_id_o, pdtc_process_id_o, mem_rd_addr_o);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_hit();
        logic [127:0] p = 128'h0123_4567_89AB_CDEF_0000_0000_ABCD_E001;
        cache_hit = 1; cache_pc = p; done_extra = 0; err_en = 0; mem_img.delete();
        run_txn(24'h000123, 20'h00045, 4'd1, 44'h100, 0, 0);
        checks++; if (!got_resp) begin errors++; $display("FAIL hit_timeout got no response exp response"); end
        checks++; if (n_lkup !== 1 || obs_rd.size() !== 0 || n_fill !== 0) begin
            errors++; $display("FAIL hit_counts got lk=%0d rd=%0d fl=%0d exp 1/0/0", n_lkup, obs_rd.size(), n_fill);
        end
        checks++; if ({r_fault, r_pc} !== {1'b0, p}) begin errors++; $display("FAIL hit_resp got %b %h exp 0 %h", r_fault, r_pc, p); end
        checks++; if (lk_dev !== 24'h000123 || lk_pid !== 20'h00045) begin
            errors++; $display("FAIL hit_ids got %h %h exp 000123 00045", lk_dev, lk_pid);
        end
        checks++; if (!idle_ok || viol !== 0) begin errors++; $display("FAIL hit_proto got idle=%b viol=%0d exp 1 0", idle_ok, viol); end
    endtask

    task automatic test_pd20_miss();
        logic [127:0] leaf = {64'h8000_0000_0001_2345, 64'h0000_0000_ABCD_E001};
        rd_t e, o;
        cache_hit = 0; cache_pc = '0; done_extra = 0; err_en = 0; mem_img.delete();
        mem_img[56'h100028] = 128'h80001;
        mem_img[56'h2005E0] = 128'hC0001;
        mem_img[56'h300DE0] = leaf;
        exp_rd.delete();
        e.addr = 56'h100028; e.size = 0; exp_rd.push_back(e);
        e.addr = 56'h2005E0; e.size = 0; exp_rd.push_back(e);
        e.addr = 56'h300DE0; e.size = 1; exp_rd.push_back(e);
        run_txn(24'h0000AA, 20'hABCDE, 4'd3, 44'h100, 0, 0);
        checks++; if (obs_rd.size() !== 3) begin errors++; $display("FAIL pd20_nreads got %0d exp 3", obs_rd.size()); end
        while (exp_rd.size() > 0 && obs_rd.size() > 0) begin
            e = exp_rd.pop_front(); o = obs_rd.pop_front();
            checks++; if (o !== e) begin errors++; $display("FAIL pd20_read got %h/%b exp %h/%b", o.addr, o.size, e.addr, e.size); end
        end
        checks++; if (n_fill !== 1 || fl_pc !== leaf) begin errors++; $display("FAIL pd20_fill got %0d %h exp 1 %h", n_fill, fl_pc, leaf); end
        checks++; if (!got_resp || r_fault !== 1'b0 || r_cause !== 12'd0 || r_pc !== leaf) begin
            errors++; $display("FAIL pd20_resp got %b %0d %h exp 0 0 %h", r_fault, r_cause, r_pc, leaf);
        end
        checks++; if (viol !== 0) begin errors++; $display("FAIL pd20_proto got %0d exp 0", viol); end
    endtask

    task automatic test_cfg_faults();
        cache_hit = 1; cache_pc = 128'h55; done_extra = 0; err_en = 0; mem_img.delete();
        run_txn(24'h1, 20'h20000, 4'd2, 44'h100, 0, 0);
        checks++; if (!got_resp || r_fault !== 1'b1 || r_cause !== 12'd260 || n_lkup !== 0) begin
            errors++; $display("FAIL pd17_wide got %b %0d lk=%0d exp 1 260 0", r_fault, r_cause, n_lkup);
        end
        run_txn(24'h1, 20'h00100, 4'd1, 44'h100, 0, 0);
        checks++; if (r_cause !== 12'd260 || n_lkup !== 0) begin errors++; $display("FAIL pd8_wide got %0d lk=%0d exp 260 0", r_cause, n_lkup); end
        run_txn(24'h1, 20'h000FF, 4'd1, 44'h100, 0, 0);
        checks++; if (r_fault !== 1'b0 || n_lkup !== 1) begin errors++; $display("FAIL pd8_edge got %b lk=%0d exp 0 1", r_fault, n_lkup); end
        run_txn(24'h1, 20'h00001, 4'd0, 44'h100, 0, 0);
        checks++; if (r_cause !== 12'd267 || n_lkup !== 0) begin errors++; $display("FAIL mode0 got %0d lk=%0d exp 267 0", r_cause, n_lkup); end
        run_txn(24'h1, 20'h00001, 4'd4, 44'h100, 0, 0);
        checks++; if (r_cause !== 12'd267) begin errors++; $display("FAIL mode4 got %0d exp 267", r_cause); end
    endtask

    task automatic test_walk_faults();
        cache_hit = 0; cache_pc = '0; done_extra = 0; err_en = 0; mem_img.delete();
        run_txn(24'h2, 20'h00123, 4'd2, 44'h400, 0, 0);
        checks++; if (r_cause !== 12'd266 || n_fill !== 0 || obs_rd.size() !== 1) begin
            errors++; $display("FAIL l1_invalid got %0d fl=%0d rd=%0d exp 266 0 1", r_cause, n_fill, obs_rd.size());
        end
        checks++; if (obs_rd.size() > 0 && obs_rd[0].addr !== 56'h400008) begin
            errors++; $display("FAIL l1_addr got %h exp 400008", obs_rd[0].addr);
        end
        mem_img[56'h400008] = 128'h80021;
        run_txn(24'h2, 20'h00123, 4'd2, 44'h400, 0, 0);
        checks++; if (r_cause !== 12'd267 || n_fill !== 0) begin errors++; $display("FAIL nl_rsvd got %0d fl=%0d exp 267 0", r_cause, n_fill); end
        err_en = 1; err_addr = 56'h50120; mem_img[56'h50120] = {64'h0, 64'hABCDE001};
        run_txn(24'h3, 20'h00012, 4'd1, 44'h50, 0, 0);
        checks++; if (r_cause !== 12'd265 || n_fill !== 0 || r_pc !== '0) begin
            errors++; $display("FAIL leaf_err got %0d fl=%0d exp 265 0", r_cause, n_fill);
        end
        err_en = 0; mem_img[56'h50120] = {64'h0, 64'hABCDE000};
        run_txn(24'h3, 20'h00012, 4'd1, 44'h50, 0, 0);
        checks++; if (r_cause !== 12'd266 || n_fill !== 0) begin errors++; $display("FAIL leaf_inv got %0d fl=%0d exp 266 0", r_cause, n_fill); end
        mem_img[56'h50120] = {64'h0, 64'hABCDE009};
        run_txn(24'h3, 20'h00012, 4'd1, 44'h50, 0, 0);
        checks++; if (r_cause !== 12'd267 || n_fill !== 0) begin errors++; $display("FAIL leaf_rsvd got %0d fl=%0d exp 267 0", r_cause, n_fill); end
    endtask

    task automatic test_handshake();
        logic [127:0] leaf = {64'h0000_0000_0000_0777, 64'h0000_0000_1234_5007};
        cache_hit = 0; cache_pc = '0; done_extra = 3; err_en = 0; mem_img.delete();
        mem_img[56'h60340] = leaf;
        run_txn(24'h4, 20'h00034, 4'd1, 44'h60, 0, 0);
        checks++; if (viol !== 0 || n_fill !== 1 || r_fault !== 1'b0 || r_pc !== leaf) begin
            errors++; $display("FAIL done_hold got viol=%0d fl=%0d %b %h exp 0 1 0 %h", viol, n_fill, r_fault, r_pc, leaf);
        end
        cache_hit = 1; cache_pc = 128'hFEED; done_extra = 0;
        run_txn(24'h5, 20'h00077, 4'd1, 44'h60, 5, 0);
        checks++; if (stall_bad !== 0 || viol !== 0 || r_pc !== 128'hFEED || !idle_ok) begin
            errors++; $display("FAIL resp_stall got bad=%0d viol=%0d pc=%h idle=%b exp 0 0 feed 1", stall_bad, viol, r_pc, idle_ok);
        end
    endtask

    task automatic test_reset_mid_walk();
        cache_hit = 0; cache_pc = '0; done_extra = 0; err_en = 0; mem_img.delete();
        run_txn(24'h6, 20'hABCDE, 4'd3, 44'h100, 0, 1);
        checks++; if (!saw_mem || mem_rd_req_o !== 1'b1) begin errors++; $display("FAIL mid_walk_reach got %b exp 1", mem_rd_req_o); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if ({mem_rd_req_o, pdtc_lookup_o, pdtc_fill_o, resp_valid_o} !== 4'b0 || req_ready_o !== 1'b1) begin
            errors++; $display("FAIL async_reset got %b rdy=%b exp 0000 1", {mem_rd_req_o, pdtc_lookup_o, pdtc_fill_o, resp_valid_o}, req_ready_o);
        end
        checks++; if ({pdtc_device_id_o, pdtc_process_id_o, mem_rd_addr_o} !== '0) begin
            errors++; $display("FAIL async_reset_ids got %h %h %h exp 0", pdtc_device_id_o, pdtc_process_id_o, mem_rd_addr_o);
        end
        repeat (2) @(negedge clk);
        checks++; if (pdtc_fill_o !== 1'b0 || mem_rd_req_o !== 1'b0) begin errors++; $display("FAIL reset_hold got %b%b exp 00", pdtc_fill_o, mem_rd_req_o); end
        rst_n = 1'b1;
        cache_hit = 1; cache_pc = 128'hBEEF;
        run_txn(24'h7, 20'h00009, 4'd1, 44'h100, 0, 0);
        checks++; if (!got_resp || r_fault !== 1'b0 || r_pc !== 128'hBEEF || n_lkup !== 1 || obs_rd.size() !== 0) begin
            errors++; $display("FAIL post_reset_hit got %b %h lk=%0d rd=%0d exp 0 beef 1 0", r_fault, r_pc, n_lkup, obs_rd.size());
        end
    endtask

    initial begin
        test_reset();
        test_hit();
        test_pd20_miss();
        test_cfg_faults();
        test_walk_faults();
        test_handshake();
        test_reset_mid_walk();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
